// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 640x480@60 path: pixel counters, sync/blank strobes
// delayed to match the palette read, and frame/vblank event pulses.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned PIPE_DLY  = 1
) (
  input  logic       VGA_CLK,
  input  logic       RESET_N,
  input  logic       PixelEn,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       Visible,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       FrameStart,
  output logic       VBlankStart
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       hs_raw;
  logic       vs_raw;
  logic       blank_raw;
  logic       frame_q;
  logic       vblank_q;

  assign h_wrap = (h_cnt == H_MAX);

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (PixelEn) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Pulses are recomputed every clock so they drop even while PixelEn is low.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      frame_q  <= PixelEn && h_wrap && (v_cnt == V_MAX);
      vblank_q <= PixelEn && h_wrap && (v_cnt == V_LAST);
    end
  end

  always_comb begin
    Visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_raw    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    blank_raw = Visible;
  end

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign VGA_HS      = hs_raw;
      assign VGA_VS      = vs_raw;
      assign VGA_BLANK_N = blank_raw;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_sr;
      logic [PIPE_DLY-1:0] vs_sr;
      logic [PIPE_DLY-1:0] bl_sr;

      // Concatenate-then-truncate shifts the raw strobe into bit 0 for any depth, including 1.
      always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          hs_sr <= '1;
          vs_sr <= '1;
          bl_sr <= '0;
        end else if (PixelEn) begin
          hs_sr <= PIPE_DLY'({hs_sr, hs_raw});
          vs_sr <= PIPE_DLY'({vs_sr, vs_raw});
          bl_sr <= PIPE_DLY'({bl_sr, blank_raw});
        end
      end

      assign VGA_HS      = hs_sr[PIPE_DLY-1];
      assign VGA_VS      = vs_sr[PIPE_DLY-1];
      assign VGA_BLANK_N = bl_sr[PIPE_DLY-1];
    end
  endgenerate

  assign DrawX       = h_cnt;
  assign DrawY       = v_cnt;
  assign VGA_SYNC_N  = 1'b0;
  assign FrameStart  = frame_q;
  assign VBlankStart = vblank_q;

endmodule
